dram4116_sync: RTL and testbench

// - Clock-sampled model of one 16Kx1 MK4116 DRAM lane. Sits directly downstream of the ula block.
// - Consumes nRAS/nCAS/nWRITE/A[6:0]; returns read data on the D bus.
// - Also checks refresh: every row must be RASed within REFRESH_LIMIT OSC cycles.
// - Drop-in for synchronous (FPGA/lint) flows where the behavioural 4116 model is unusable.

---
 rtl/dram4116_sync.sv | 174 +++++++++++++++++
 tb/tb_dram4116_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dram4116_sync.sv
// Clock-sampled model of one 16Kx1 MK4116 DRAM lane with a row-refresh watchdog.
// Strobes are registered once, and each action fires on the cycle after its edge is seen.
module dram4116_sync #(
  parameter int   REFRESH_LIMIT = 28000,
  parameter int   CNT_W         = 16,
  parameter logic INIT_VAL      = 1'b0
) (
  input  logic       OSC,
  input  logic       RESET,
  input  logic       nRAS,
  input  logic       nCAS,
  input  logic       nWRITE,
  input  logic [6:0] A,
  input  logic       Din,
  output logic       Dout,
  output logic       Dout_en,
  output logic       refresh_err,
  output logic [6:0] err_row
);

  typedef enum logic [1:0] {IDLE, ROW, RD, WR} state_t;

  state_t state, state_nxt;

  logic             s_ras, s_cas, s_we, s_din;
  logic [6:0]       s_a;
  logic             ras_prev, cas_prev, we_prev;
  logic             ras_fall, ras_rise, cas_fall, cas_rise, we_fall;

  logic [6:0]       row_lat, col_lat;
  logic             rd_pend;
  logic             row_ld, col_ld, rd_ld, oe_clr, mem_we;
  logic [13:0]      mem_waddr;

  logic             mem [0:16383] = '{default: INIT_VAL};
  logic [CNT_W-1:0] stamp [0:127];
  logic [127:0]     seen;
  logic [CNT_W-1:0] now;
  logic [6:0]       scan;
  logic [CNT_W-1:0] base, age;

  // Input sampling stage and edge history
  always_ff @(posedge OSC or posedge RESET) begin
    if (RESET) begin
      s_ras    <= 1'b1;
      s_cas    <= 1'b1;
      s_we     <= 1'b1;
      s_din    <= 1'b0;
      s_a      <= '0;
      ras_prev <= 1'b1;
      cas_prev <= 1'b1;
      we_prev  <= 1'b1;
    end else begin
      s_ras    <= nRAS;
      s_cas    <= nCAS;
      s_we     <= nWRITE;
      s_din    <= Din;
      s_a      <= A;
      ras_prev <= s_ras;
      cas_prev <= s_cas;
      we_prev  <= s_we;
    end
  end

  assign ras_fall = ras_prev & ~s_ras;
  assign ras_rise = ~ras_prev & s_ras;
  assign cas_fall = cas_prev & ~s_cas;
  assign cas_rise = ~cas_prev & s_cas;
  assign we_fall  = we_prev & ~s_we;

  always_ff @(posedge OSC or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_ld    = 1'b0;
    col_ld    = 1'b0;
    rd_ld     = 1'b0;
    oe_clr    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {row_lat, s_a};
    case (state)
      IDLE: begin
        // A simultaneous CAS fall is dropped here; only a later CAS fall opens a column.
        if (ras_fall) begin
          row_ld    = 1'b1;
          state_nxt = ROW;
        end
      end
      ROW: begin
        if (ras_rise) begin
          state_nxt = IDLE;
        end else if (cas_fall) begin
          if (!s_we) begin
            mem_we    = 1'b1;
            state_nxt = WR;
          end else begin
            col_ld    = 1'b1;
            rd_ld     = 1'b1;
            state_nxt = RD;
          end
        end
      end
      RD, WR: begin
        // RAS may cycle underneath a held CAS (hidden refresh); the data phase persists.
        if (ras_fall) row_ld = 1'b1;
        if (cas_rise) begin
          oe_clr    = 1'b1;
          state_nxt = s_ras ? IDLE : ROW;
        end else if (state == RD && we_fall) begin
          mem_we    = 1'b1;
          mem_waddr = {row_lat, col_lat};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address latches and read output stage
  always_ff @(posedge OSC or posedge RESET) begin
    if (RESET) begin
      row_lat <= '0;
      col_lat <= '0;
      rd_pend <= 1'b0;
      Dout    <= 1'b0;
      Dout_en <= 1'b0;
    end else begin
      if (row_ld) row_lat <= s_a;
      if (col_ld) col_lat <= s_a;
      rd_pend <= rd_ld;
      if (rd_pend) Dout <= mem[{row_lat, col_lat}];
      if (oe_clr)       Dout_en <= 1'b0;
      else if (rd_pend) Dout_en <= 1'b1;
    end
  end

  always_ff @(posedge OSC) begin
    if (mem_we) mem[mem_waddr] <= s_din;
  end

  always_ff @(posedge OSC) begin
    if (row_ld) stamp[s_a] <= now;
  end

  // A row stamped in the same cycle it is scanned counts as freshly refreshed.
  always_comb begin
    if (row_ld && (s_a == scan)) base = now;
    else if (seen[scan])         base = stamp[scan];
    else                         base = '0;
    age = now - base;
  end

  // Refresh watchdog stage
  always_ff @(posedge OSC or posedge RESET) begin
    if (RESET) begin
      now         <= '0;
      scan        <= '0;
      seen        <= '0;
      refresh_err <= 1'b0;
      err_row     <= '0;
    end else begin
      now  <= now + 1'b1;
      scan <= scan + 1'b1;
      if (row_ld) seen[s_a] <= 1'b1;
      if (!refresh_err && (age > CNT_W'(REFRESH_LIMIT))) begin
        refresh_err <= 1'b1;
        err_row     <= scan;
      end
    end
  end

endmodule

// File: tb/tb_dram4116_sync.sv
// Directed bench for dram4116_sync: array access, output-enable timing and refresh watchdog.
module tb_dram4116_sync;

  logic       OSC = 1'b0;
  logic       RESET;
  logic       nRAS, nCAS, nWRITE, Din;
  logic [6:0] A;
  logic       Dout, Dout_en, refresh_err;
  logic [6:0] err_row;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_cyc = -1;
  int t5 = 0;

  dram4116_sync #(.REFRESH_LIMIT(1000), .CNT_W(16), .INIT_VAL(1'b0)) dut (
    .OSC(OSC), .RESET(RESET), .nRAS(nRAS), .nCAS(nCAS), .nWRITE(nWRITE),
    .A(A), .Din(Din), .Dout(Dout), .Dout_en(Dout_en),
    .refresh_err(refresh_err), .err_row(err_row)
  );

  always #5 OSC = ~OSC;
  always @(posedge OSC) cyc <= cyc + 1;
  always @(negedge OSC) if (refresh_err && err_cyc < 0) err_cyc = cyc;

  task automatic tick(input int n);
    repeat (n) @(negedge OSC);
  endtask

  task automatic do_reset();
    nRAS = 1; nCAS = 1; nWRITE = 1; Din = 0; A = '0;
    RESET = 1;
    tick(3);
    RESET = 0;
    tick(1);
    err_cyc = -1;
  endtask

  task automatic ras_open(input logic [6:0] r);
    A = r; nRAS = 0;
    tick(3);
  endtask

  task automatic cycle_close();
    nCAS = 1; nRAS = 1; nWRITE = 1;
    tick(3);
  endtask

  task automatic early_write(input logic [6:0] r, input logic [6:0] c, input logic d);
    ras_open(r);
    A = c; Din = d; nWRITE = 0; nCAS = 0;
    tick(3);
    cycle_close();
  endtask

  // Leaves the read cycle open with Dout valid.
  task automatic read_open(input logic [6:0] r, input logic [6:0] c);
    ras_open(r);
    A = c; nWRITE = 1; nCAS = 0;
    tick(3);
  endtask

  task automatic strobe_row(input logic [6:0] r);
    A = r; nRAS = 0;
    tick(2);
    nRAS = 1;
    tick(2);
  endtask

  task automatic refresh_pass(input int skip);
    int start;
    start = cyc;
    for (int r = 0; r < 128; r++) begin
      if (r != skip) begin
        if (r == 5) t5 = cyc;
        strobe_row(7'(r));
      end
    end
    while (cyc - start < 900) tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (Dout !== 1'b0) begin n_bad++; $display("FAIL reset_dout: got %b want 0", Dout); end
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL reset_dout_en: got %b want 0", Dout_en); end
    n_cmp++; if (refresh_err !== 1'b0) begin n_bad++; $display("FAIL reset_refresh_err: got %b want 0", refresh_err); end
    n_cmp++; if (err_row !== 7'h00) begin n_bad++; $display("FAIL reset_err_row: got %h want 00", err_row); end
  endtask

  task automatic test_early_write();
    ras_open(7'h12);
    A = 7'h34; Din = 1; nWRITE = 0; nCAS = 0;
    tick(3);
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL ew_write_oe: got %b want 0", Dout_en); end
    cycle_close();
    ras_open(7'h12);
    A = 7'h34; nWRITE = 1; nCAS = 0;
    tick(2);
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL ew_read_oe_early: got %b want 0", Dout_en); end
    tick(1);
    n_cmp++; if (Dout_en !== 1'b1) begin n_bad++; $display("FAIL ew_read_oe: got %b want 1", Dout_en); end
    n_cmp++; if (Dout !== 1'b1) begin n_bad++; $display("FAIL ew_read_data: got %b want 1", Dout); end
    cycle_close();
    read_open(7'h12, 7'h35);
    n_cmp++; if (Dout !== 1'b0) begin n_bad++; $display("FAIL ew_neighbour: got %b want 0", Dout); end
    cycle_close();
  endtask

  task automatic test_rmw();
    read_open(7'h20, 7'h01);
    n_cmp++; if (Dout !== 1'b0 || Dout_en !== 1'b1) begin n_bad++; $display("FAIL rmw_read: got %b/%b want 0/1", Dout, Dout_en); end
    Din = 1; nWRITE = 0;
    tick(3);
    n_cmp++; if (Dout !== 1'b0) begin n_bad++; $display("FAIL rmw_hold_data: got %b want 0", Dout); end
    n_cmp++; if (Dout_en !== 1'b1) begin n_bad++; $display("FAIL rmw_hold_oe: got %b want 1", Dout_en); end
    cycle_close();
    read_open(7'h20, 7'h01);
    n_cmp++; if (Dout !== 1'b1) begin n_bad++; $display("FAIL rmw_readback: got %b want 1", Dout); end
    cycle_close();
  endtask

  task automatic test_output_control();
    read_open(7'h12, 7'h34);
    nRAS = 1;
    tick(4);
    n_cmp++; if (Dout_en !== 1'b1 || Dout !== 1'b1) begin n_bad++; $display("FAIL oc_tail: got %b/%b want 1/1", Dout_en, Dout); end
    nCAS = 1;
    tick(1);
    n_cmp++; if (Dout_en !== 1'b1) begin n_bad++; $display("FAIL oc_cas_rise_sampled: got %b want 1", Dout_en); end
    tick(1);
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL oc_off: got %b want 0", Dout_en); end
    cycle_close();
  endtask

  task automatic test_edge_cases();
    // CAS before RAS: no read phase may open.
    A = 7'h12; nCAS = 0;
    tick(4);
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL cbr_oe: got %b want 0", Dout_en); end
    cycle_close();
    // RAS and CAS falling together with write low: CAS is ignored, so no write lands.
    A = 7'h40; Din = 1; nWRITE = 0; nRAS = 0; nCAS = 0;
    tick(4);
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL same_edge_oe: got %b want 0", Dout_en); end
    cycle_close();
    read_open(7'h40, 7'h40);
    n_cmp++; if (Dout !== 1'b0) begin n_bad++; $display("FAIL same_edge_nowrite: got %b want 0", Dout); end
    cycle_close();
  endtask

  task automatic test_reset_mid_read();
    read_open(7'h12, 7'h34);
    n_cmp++; if (Dout_en !== 1'b1) begin n_bad++; $display("FAIL rst_pre_oe: got %b want 1", Dout_en); end
    #2 RESET = 1;
    #1;
    n_cmp++; if (Dout_en !== 1'b0) begin n_bad++; $display("FAIL rst_async_oe: got %b want 0", Dout_en); end
    nRAS = 1; nCAS = 1; nWRITE = 1;
    tick(2);
    RESET = 0;
    tick(2);
    read_open(7'h12, 7'h34);
    n_cmp++; if (Dout !== 1'b1 || Dout_en !== 1'b1) begin n_bad++; $display("FAIL rst_retained: got %b/%b want 1/1", Dout, Dout_en); end
    cycle_close();
  endtask

  task automatic test_refresh_pass();
    do_reset();
    for (int p = 0; p < 12; p++) refresh_pass(-1);
    n_cmp++; if (err_cyc !== -1) begin n_bad++; $display("FAIL refresh_pass_flag_seen: got cycle %0d want none", err_cyc); end
    n_cmp++; if (refresh_err !== 1'b0) begin n_bad++; $display("FAIL refresh_pass_err: got %b want 0", refresh_err); end
  endtask

  task automatic test_refresh_fail();
    int elapsed;
    do_reset();
    refresh_pass(-1);
    for (int p = 0; p < 3; p++) refresh_pass(5);
    n_cmp++; if (refresh_err !== 1'b1) begin n_bad++; $display("FAIL refresh_fail_err: got %b want 1", refresh_err); end
    n_cmp++; if (err_row !== 7'h05) begin n_bad++; $display("FAIL refresh_fail_row: got %h want 05", err_row); end
    // Strobe-to-flag span includes the two-cycle pin-to-action latency.
    elapsed = (err_cyc < 0) ? -1 : err_cyc - t5;
    n_cmp++; if (elapsed < 1003 || elapsed > 1130) begin n_bad++; $display("FAIL refresh_fail_delay: got %0d want 1003..1130", elapsed); end
    strobe_row(7'h05);
    tick(200);
    n_cmp++; if (refresh_err !== 1'b1 || err_row !== 7'h05) begin n_bad++; $display("FAIL refresh_sticky: got %b/%h want 1/05", refresh_err, err_row); end
  endtask

  initial begin
    test_reset();
    test_early_write();
    test_rmw();
    test_output_control();
    test_edge_cases();
    test_reset_mid_read();
    test_refresh_pass();
    test_refresh_fail();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
